// File: rtl/vadd_lane_core_if.sv
// ============================================================================
// vadd_lane_core_if
// ----------------------------------------------------------------------------
// Stream bundle for vadd_lane_core: two operand streams (A and B) feeding
// the core and one result stream leaving it. Both operand streams and the
// result stream are LANES*DATA_WIDTH bits wide.
//
// Parameters
//   DATA_WIDTH : per-lane operand width in bits
//   LANES      : lanes carried per beat
//
// Modports
//   slave  : the core's view (consumes A/B, produces the result stream)
//   master : the host/environment view (produces A/B, consumes results)
//
// Signals
//   s_a_tvalid / s_a_tready / s_a_tdata : operand A stream
//   s_b_tvalid / s_b_tready / s_b_tdata : operand B stream
//   m_tvalid / m_tready / m_tdata / m_tlast : result stream
// ============================================================================
interface vadd_lane_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);
    logic                          s_a_tvalid;
    logic                          s_a_tready;
    logic [LANES*DATA_WIDTH-1:0]   s_a_tdata;

    logic                          s_b_tvalid;
    logic                          s_b_tready;
    logic [LANES*DATA_WIDTH-1:0]   s_b_tdata;

    logic                          m_tvalid;
    logic                          m_tready;
    logic [LANES*DATA_WIDTH-1:0]   m_tdata;
    logic                          m_tlast;

    modport slave (
        input  s_a_tvalid,
        input  s_a_tdata,
        output s_a_tready,
        input  s_b_tvalid,
        input  s_b_tdata,
        output s_b_tready,
        output m_tvalid,
        output m_tdata,
        output m_tlast,
        input  m_tready
    );

    modport master (
        output s_a_tvalid,
        output s_a_tdata,
        input  s_a_tready,
        output s_b_tvalid,
        output s_b_tdata,
        input  s_b_tready,
        input  m_tvalid,
        input  m_tdata,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/vadd_lane_core.sv
// ============================================================================
// vadd_lane_core
// ----------------------------------------------------------------------------
// Multi-lane vector adder/subtractor with an ap_ctrl style start/done
// handshake. A run is launched with ap_start while idle; the core then
// consumes `length` beats from the A and B streams (always jointly, in the
// same cycle), computes every lane independently and emits one result beat
// per consumed pair on the result stream, with m_tlast on the final beat.
//
// Operation codes (latched at start):
//   00 : add, modulo 2^DATA_WIDTH
//   01 : subtract A-B, modulo 2^DATA_WIDTH
//   10 : saturating add (clamps to all-ones on carry) when the macro
//        VADD_LANE_CORE_SAT_EN is defined; otherwise identical to add
//   11 : treated as add
//
// Configuration macro
//   VADD_LANE_CORE_SAT_EN : builds the saturation clamp for mode 10.
//
// Parameters
//   DATA_WIDTH : per-lane operand width (8..64)
//   LANES      : lanes per beat (1..16)
//   LEN_WIDTH  : width of the beat-count input
//
// Ports
//   ap_clk      : clock, rising edge
//   ap_rst_n    : asynchronous active-low reset
//   ap_start    : run launch, sampled only while idle
//   ap_done     : one-cycle pulse when a run completes
//   ap_ready    : one-cycle pulse, ready for a new start (same cycle as done)
//   ap_idle     : high only while idle
//   length      : number of beats in the run, latched at start
//   mode        : operation code, latched at start
//   carry_seen  : sticky, some lane carried (add modes) or borrowed (sub)
//                 during the current or most recent run
//   axis        : stream bundle (slave view)
// ============================================================================
module vadd_lane_core #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_ready,
    output logic                 ap_idle,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [1:0]           mode,
    output logic                 carry_seen,
    vadd_lane_core_if.slave      axis
);

    localparam int BUS_W = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [LEN_WIDTH-1:0]   remaining_reg;
    logic [1:0]             mode_reg;
    logic                   carry_seen_reg;
    logic                   m_tvalid_reg;
    logic                   m_tlast_reg;
    logic [BUS_W-1:0]       m_tdata_reg;
    logic                   ap_done_reg;
    logic                   ap_ready_reg;
    logic                   ap_idle_reg;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // The single output register may take a new beat when it is empty or
    // when its current beat leaves in this same cycle.
    logic out_free;
    logic accept;
    logic out_fire;
    logic last_beat;

    assign out_free  = !m_tvalid_reg || axis.m_tready;
    assign accept    = (state_reg == RUN) && axis.s_a_tvalid
                       && axis.s_b_tvalid && out_free;
    assign out_fire  = m_tvalid_reg && axis.m_tready;
    assign last_beat = (remaining_reg == LEN_WIDTH'(1));

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    logic sub_sel;
    assign sub_sel = (mode_reg == 2'b01);

`ifdef VADD_LANE_CORE_SAT_EN
    logic sat_sel;
    assign sat_sel = (mode_reg == 2'b10);
`endif

    logic [BUS_W-1:0] result_next;
    logic [LANES-1:0] lane_carry_next;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_lane;
        logic [DATA_WIDTH-1:0] b_lane;
        logic [DATA_WIDTH:0]   sum_ext;
        logic [DATA_WIDTH:0]   diff_ext;

        assign a_lane   = axis.s_a_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_lane   = axis.s_b_tdata[gi*DATA_WIDTH +: DATA_WIDTH];

        // One extra bit on each side: the MSB of the sum is the carry out,
        // the MSB of the difference is set exactly when A < B (borrow).
        assign sum_ext  = {1'b0, a_lane} + {1'b0, b_lane};
        assign diff_ext = {1'b0, a_lane} - {1'b0, b_lane};

        assign lane_carry_next[gi] = sub_sel ? diff_ext[DATA_WIDTH]
                                             : sum_ext[DATA_WIDTH];

`ifdef VADD_LANE_CORE_SAT_EN
        assign result_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            sub_sel                         ? diff_ext[DATA_WIDTH-1:0] :
            (sat_sel && sum_ext[DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}       :
                                              sum_ext[DATA_WIDTH-1:0];
`else
        assign result_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            sub_sel ? diff_ext[DATA_WIDTH-1:0] : sum_ext[DATA_WIDTH-1:0];
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            mode_reg       <= 2'b00;
            carry_seen_reg <= 1'b0;
            m_tvalid_reg   <= 1'b0;
            m_tlast_reg    <= 1'b0;
            m_tdata_reg    <= '0;
            ap_done_reg    <= 1'b0;
            ap_ready_reg   <= 1'b0;
            ap_idle_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ap_start) begin
                        mode_reg       <= mode;
                        carry_seen_reg <= 1'b0;
                        ap_idle_reg    <= 1'b0;
                        if (length != '0) begin
                            remaining_reg <= length;
                            state_reg     <= RUN;
                        end else begin
                            // Empty run: report completion without
                            // touching either stream.
                            state_reg    <= DONE;
                            ap_done_reg  <= 1'b1;
                            ap_ready_reg <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (accept) begin
                        m_tvalid_reg  <= 1'b1;
                        m_tdata_reg   <= result_next;
                        m_tlast_reg   <= last_beat;
                        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                        if (|lane_carry_next) begin
                            carry_seen_reg <= 1'b1;
                        end
                        if (last_beat) begin
                            state_reg <= DRAIN;
                        end
                    end else if (out_fire) begin
                        m_tvalid_reg <= 1'b0;
                        m_tlast_reg  <= 1'b0;
                    end
                end

                DRAIN: begin
                    // The output register holds the tlast beat here; the
                    // run finishes once it has been taken.
                    if (out_fire) begin
                        m_tvalid_reg <= 1'b0;
                        m_tlast_reg  <= 1'b0;
                        state_reg    <= DONE;
                        ap_done_reg  <= 1'b1;
                        ap_ready_reg <= 1'b1;
                    end
                end

                DONE: begin
                    ap_done_reg  <= 1'b0;
                    ap_ready_reg <= 1'b0;
                    ap_idle_reg  <= 1'b1;
                    state_reg    <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign ap_done         = ap_done_reg;
    assign ap_ready        = ap_ready_reg;
    assign ap_idle         = ap_idle_reg;
    assign carry_seen      = carry_seen_reg;

    // A and B are always taken together.
    assign axis.s_a_tready = accept;
    assign axis.s_b_tready = accept;

    assign axis.m_tvalid   = m_tvalid_reg;
    assign axis.m_tdata    = m_tdata_reg;
    assign axis.m_tlast    = m_tlast_reg;

endmodule

// File: tb/tb_vadd_lane_core.sv
`timescale 1ns/1ps
module tb_vadd_lane_core;
    localparam int DW = 32;
    localparam int LN = 4;
    localparam int LW = 32;
    localparam int BW = DW * LN;
    localparam longint unsigned MODV = 64'h1_0000_0000;
    localparam longint unsigned MAXV = 64'h0_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_done, ap_ready, ap_idle, carry_seen;
    logic [LW-1:0] length = '0;
    logic [1:0]    mode = 2'b00;

    vadd_lane_core_if #(.DATA_WIDTH(DW), .LANES(LN)) axis();

    vadd_lane_core #(.DATA_WIDTH(DW), .LANES(LN), .LEN_WIDTH(LW)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .length(length), .mode(mode), .carry_seen(carry_seen),
        .axis(axis)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] a_beats[$];
    logic [BW-1:0] b_beats[$];
    logic [BW-1:0] got_data[$];
    logic          got_last[$];
    int stab_errs, ready_errs, idle_errs, early_done, done_lat, cyc_used, stall_full;
    logic done_ready, post_ok, timed_out;

    // Reference model: per-lane unsigned arithmetic on wide integers.
    function automatic logic [BW-1:0] model_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                                 input logic [1:0] md, output logic c);
        logic [BW-1:0] r;
        longint unsigned x, y, s;
        r = '0;
        c = 1'b0;
        for (int l = 0; l < LN; l++) begin
            x = {32'b0, a[l*DW +: DW]};
            y = {32'b0, b[l*DW +: DW]};
            case (md)
                2'b01: begin
                    if (x < y) begin s = x + MODV - y; c = 1'b1; end
                    else s = x - y;
                end
`ifdef VADD_LANE_CORE_SAT_EN
                2'b10: begin
                    s = x + y;
                    if (s > MAXV) begin s = MAXV; c = 1'b1; end
                end
`endif
                default: begin
                    s = x + y;
                    if (s > MAXV) begin s = s - MODV; c = 1'b1; end
                end
            endcase
            r[l*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bus();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_random(input int n);
        a_beats.delete();
        b_beats.delete();
        for (int i = 0; i < n; i++) begin
            a_beats.push_back(rand_bus());
            b_beats.push_back(rand_bus());
        end
    endtask

    // Drives one run and records what the DUT produced and any protocol slips.
    task automatic run_stream(input int n, input logic [1:0] md, input int vpct, input int rpct,
                              input int stall_at, input int stop_after);
        int ia, stall_cnt;
        logic prev_hold, prev_last, av, bv, exp_rdy;
        logic [BW-1:0] prev_data;
        got_data.delete();
        got_last.delete();
        stab_errs = 0; ready_errs = 0; idle_errs = 0; early_done = 0; stall_full = 0;
        @(negedge clk);
        length = LW'(n);
        mode = md;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        ia = 0; stall_cnt = 0; prev_hold = 1'b0; prev_last = 1'b0; prev_data = '0; cyc_used = 0;
        while (got_data.size() < n && got_data.size() < stop_after && cyc_used < 2000) begin
            if (prev_hold && (axis.m_tvalid !== 1'b1 || axis.m_tdata !== prev_data
                              || axis.m_tlast !== prev_last)) stab_errs++;
            if (ap_idle !== 1'b0) idle_errs++;
            if (ap_done !== 1'b0) early_done++;
            if (ia < n) begin
                ap_start = 1'($urandom_range(1));
                length = $urandom;
                mode = 2'($urandom);
            end else begin
                ap_start = 1'b0;
            end
            av = (ia < n) && ($urandom_range(99) < vpct);
            bv = (ia < n) && ($urandom_range(99) < vpct);
            axis.s_a_tvalid = av;
            axis.s_b_tvalid = bv;
            if (av) axis.s_a_tdata = a_beats[ia]; else axis.s_a_tdata = rand_bus();
            if (bv) axis.s_b_tdata = b_beats[ia]; else axis.s_b_tdata = rand_bus();
            if (stall_at >= 0 && got_data.size() == stall_at && stall_cnt < 5) begin
                axis.m_tready = 1'b0;
                stall_cnt++;
                if (axis.m_tvalid === 1'b1) stall_full++;
            end else begin
                axis.m_tready = ($urandom_range(99) < rpct);
            end
            #1;
            exp_rdy = (ia < n) && av && bv && (!axis.m_tvalid || axis.m_tready);
            if (axis.s_a_tready !== exp_rdy || axis.s_b_tready !== exp_rdy) ready_errs++;
            if (exp_rdy) ia++;
            if (axis.m_tvalid === 1'b1 && axis.m_tready) begin
                got_data.push_back(axis.m_tdata);
                got_last.push_back(axis.m_tlast);
            end
            prev_hold = axis.m_tvalid && !axis.m_tready;
            prev_data = axis.m_tdata;
            prev_last = axis.m_tlast;
            @(negedge clk);
            cyc_used++;
        end
        timed_out = (cyc_used >= 2000);
        axis.s_a_tvalid = 1'b0;
        axis.s_b_tvalid = 1'b0;
        axis.m_tready = 1'b1;
        ap_start = 1'b0;
        done_lat = 99; done_ready = 1'b0; post_ok = 1'b0;
        if (stop_after >= n) begin
            for (int k = 0; k < 6; k++) begin
                if (ap_done === 1'b1) begin
                    done_lat = k;
                    done_ready = (ap_ready === 1'b1);
                    break;
                end
                @(negedge clk);
            end
            if (done_lat != 99) begin
                @(negedge clk);
                post_ok = (ap_done === 1'b0 && ap_ready === 1'b0 && ap_idle === 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        axis.s_a_tvalid = 1'b1; axis.s_b_tvalid = 1'b1; axis.m_tready = 1'b1;
        axis.s_a_tdata = rand_bus(); axis.s_b_tdata = rand_bus();
        ap_start = 1'b1; length = 32'd4;
        repeat (3) @(negedge clk);
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
        checks++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin errors++; $display("FAIL reset_done_ready: got %b%b expected 00", ap_done, ap_ready); end
        checks++; if (axis.s_a_tready !== 1'b0 || axis.s_b_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b%b expected 00", axis.s_a_tready, axis.s_b_tready); end
        checks++; if (axis.m_tvalid !== 1'b0 || axis.m_tlast !== 1'b0) begin errors++; $display("FAIL reset_mvalid_last: got %b%b expected 00", axis.m_tvalid, axis.m_tlast); end
        checks++; if (axis.m_tdata !== '0) begin errors++; $display("FAIL reset_mdata: got %h expected 0", axis.m_tdata); end
        checks++; if (carry_seen !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_seen); end
        ap_start = 1'b0;
        axis.s_a_tvalid = 1'b0; axis.s_b_tvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_release_idle: got %b expected 1", ap_idle); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [BW-1:0] exp_beat;
        a_beats.delete(); b_beats.delete();
        for (int i = 0; i < 3; i++) begin
            a_beats.push_back({32'd4, 32'd3, 32'd2, 32'd1});
            b_beats.push_back({32'd10, 32'd10, 32'd10, 32'd10});
        end
        exp_beat = {32'd14, 32'd13, 32'd12, 32'd11};
        run_stream(3, 2'b00, 100, 100, -1, 3);
        checks++; if (got_data.size() != 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", got_data.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_data.size() || got_data[i] !== exp_beat || got_last[i] !== (i == 2)) begin
                errors++; $display("FAIL basic_beat%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], exp_beat, (i == 2));
            end
        end
        checks++; if (done_lat != 0 || !done_ready) begin errors++; $display("FAIL basic_done: got latency %0d ready %b expected 0 1", done_lat, done_ready); end
        checks++; if (!post_ok) begin errors++; $display("FAIL basic_done_width: got post-done state not idle expected idle"); end
        checks++; if (cyc_used != 4) begin errors++; $display("FAIL basic_throughput: got %0d cycles expected 4", cyc_used); end
        checks++; if (ready_errs != 0 || stab_errs != 0 || idle_errs != 0 || early_done != 0) begin errors++; $display("FAIL basic_protocol: got rdy %0d stab %0d idle %0d early %0d expected 0", ready_errs, stab_errs, idle_errs, early_done); end
        checks++; if (carry_seen !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b expected 0", carry_seen); end
        $display("test_basic: %0d beats in %0d cycles, done latency %0d", got_data.size(), cyc_used, done_lat);
    endtask

    task automatic test_sub_borrow();
        logic [BW-1:0] a, b, exp_beat;
        logic c;
        a = rand_bus(); b = rand_bus();
        a[DW-1:0] = 32'd0; b[DW-1:0] = 32'd1;
        a_beats.delete(); b_beats.delete();
        a_beats.push_back(a); b_beats.push_back(b);
        exp_beat = model_beat(a, b, 2'b01, c);
        run_stream(1, 2'b01, 100, 100, -1, 1);
        checks++; if (got_data.size() != 1 || got_data[0][DW-1:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_lane0: got %h expected ffffffff", got_data[0][DW-1:0]); end
        checks++; if (got_data.size() != 1 || got_data[0] !== exp_beat || got_last[0] !== 1'b1) begin errors++; $display("FAIL sub_beat: got %h expected %h", got_data[0], exp_beat); end
        checks++; if (carry_seen !== 1'b1) begin errors++; $display("FAIL sub_carry: got %b expected 1", carry_seen); end
        $display("test_sub_borrow: lane0 %h carry_seen %b", got_data[0][DW-1:0], carry_seen);
    endtask

    task automatic test_saturate();
        logic [BW-1:0] a, b;
        logic [DW-1:0] exp_lane0;
`ifdef VADD_LANE_CORE_SAT_EN
        exp_lane0 = 32'hFFFF_FFFF;
`else
        exp_lane0 = 32'h0000_0010;
`endif
        a = {32'd7, 32'd6, 32'd5, 32'hFFFF_FFF0};
        b = {32'd1, 32'd1, 32'd1, 32'h0000_0020};
        a_beats.delete(); b_beats.delete();
        a_beats.push_back(a); b_beats.push_back(b);
        run_stream(1, 2'b10, 100, 100, -1, 1);
        checks++; if (got_data.size() != 1 || got_data[0] !== {32'd8, 32'd7, 32'd6, exp_lane0}) begin errors++; $display("FAIL sat_beat: got %h expected %h", got_data[0], {32'd8, 32'd7, 32'd6, exp_lane0}); end
        checks++; if (carry_seen !== 1'b1) begin errors++; $display("FAIL sat_carry: got %b expected 1", carry_seen); end
        $display("test_saturate: lane0 %h", got_data[0][DW-1:0]);
    endtask

    task automatic test_zero_length();
        int done_at, done_cnt, rdy_cnt, mv_cnt;
        done_at = 99; done_cnt = 0; rdy_cnt = 0; mv_cnt = 0;
        axis.s_a_tvalid = 1'b1; axis.s_b_tvalid = 1'b1; axis.m_tready = 1'b1;
        @(negedge clk);
        length = '0; ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (ap_done === 1'b1) begin done_cnt++; if (done_at == 99) done_at = k; end
            if (axis.s_a_tready !== 1'b0 || axis.s_b_tready !== 1'b0) rdy_cnt++;
            if (axis.m_tvalid !== 1'b0) mv_cnt++;
            @(negedge clk);
        end
        axis.s_a_tvalid = 1'b0; axis.s_b_tvalid = 1'b0;
        checks++; if (done_at >= 2 || done_cnt != 1) begin errors++; $display("FAIL zero_done: got at %0d pulses %0d expected <2 and 1", done_at, done_cnt); end
        checks++; if (rdy_cnt != 0 || mv_cnt != 0) begin errors++; $display("FAIL zero_stream: got tready %0d mvalid %0d cycles expected 0", rdy_cnt, mv_cnt); end
        checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL zero_idle: got %b expected 1", ap_idle); end
        $display("test_zero_length: done at cycle %0d", done_at);
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] exp_beat;
        logic c;
        int bad;
        fill_random(8);
        run_stream(8, 2'b00, 100, 100, 3, 8);
        bad = 0;
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got_data.size()); end
        for (int i = 0; i < 8; i++) begin
            exp_beat = model_beat(a_beats[i], b_beats[i], 2'b00, c);
            checks++;
            if (i >= got_data.size() || got_data[i] !== exp_beat || got_last[i] !== (i == 7)) begin
                errors++; bad++; $display("FAIL bp_beat%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], exp_beat, (i == 7));
            end
        end
        checks++; if (stall_full != 5) begin errors++; $display("FAIL bp_stall_full: got %0d expected 5", stall_full); end
        checks++; if (stab_errs != 0 || ready_errs != 0) begin errors++; $display("FAIL bp_protocol: got stab %0d rdy %0d expected 0", stab_errs, ready_errs); end
        checks++; if (done_lat != 0) begin errors++; $display("FAIL bp_done: got %0d expected 0", done_lat); end
        $display("test_backpressure: %0d beats, %0d bad", got_data.size(), bad);
    endtask

    task automatic test_random_modes();
        logic [BW-1:0] exp_beat;
        logic c, exp_carry;
        logic [1:0] md;
        int n;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(10, 1);
            md = 2'($urandom);
            fill_random(n);
            if (r % 2 == 1) begin
                // small operands so carry_seen can also be exercised as 0
                for (int i = 0; i < n; i++) begin
                    a_beats[i] = a_beats[i] & {4{32'h0000_FFFF}};
                    b_beats[i] = b_beats[i] & {4{32'h0000_FFFF}};
                    if (md == 2'b01) b_beats[i] = a_beats[i] >> 1;
                end
            end
            run_stream(n, md, 70, 60, -1, n);
            exp_carry = 1'b0;
            checks++; if (got_data.size() != n) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", r, got_data.size(), n); end
            for (int i = 0; i < n; i++) begin
                exp_beat = model_beat(a_beats[i], b_beats[i], md, c);
                exp_carry |= c;
                checks++;
                if (i >= got_data.size() || got_data[i] !== exp_beat || got_last[i] !== (i == n - 1)) begin
                    errors++; $display("FAIL rnd%0d_beat%0d: got %h last %b expected %h last %b", r, i, got_data[i], got_last[i], exp_beat, (i == n - 1));
                end
            end
            checks++; if (carry_seen !== exp_carry) begin errors++; $display("FAIL rnd%0d_carry: got %b expected %b", r, carry_seen, exp_carry); end
            checks++; if (ready_errs != 0 || stab_errs != 0 || idle_errs != 0 || early_done != 0 || timed_out) begin errors++; $display("FAIL rnd%0d_protocol: got rdy %0d stab %0d idle %0d early %0d to %b expected 0", r, ready_errs, stab_errs, idle_errs, early_done, timed_out); end
            checks++; if (done_lat != 0 || !post_ok) begin errors++; $display("FAIL rnd%0d_done: got latency %0d post %b expected 0 1", r, done_lat, post_ok); end
            $display("test_random_modes: run %0d mode %0d len %0d cycles %0d carry %b", r, md, n, cyc_used, carry_seen);
        end
    endtask

    task automatic test_reset_abort();
        logic [BW-1:0] exp_beat;
        logic c;
        int done_cnt;
        fill_random(6);
        for (int i = 0; i < 6; i++) a_beats[i] = a_beats[i] | {4{32'h8000_0000}};
        for (int i = 0; i < 6; i++) b_beats[i] = b_beats[i] | {4{32'h8000_0000}};
        run_stream(6, 2'b00, 100, 100, -1, 2);
        axis.s_a_tvalid = 1'b1; axis.s_b_tvalid = 1'b1; axis.m_tready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (axis.m_tvalid !== 1'b0 || axis.m_tlast !== 1'b0 || axis.m_tdata !== '0) begin errors++; $display("FAIL abort_mout: got v%b l%b %h expected all 0", axis.m_tvalid, axis.m_tlast, axis.m_tdata); end
        checks++; if (axis.s_a_tready !== 1'b0 || axis.s_b_tready !== 1'b0) begin errors++; $display("FAIL abort_tready: got %b%b expected 00", axis.s_a_tready, axis.s_b_tready); end
        checks++; if (ap_idle !== 1'b1 || carry_seen !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got idle %b carry %b expected 1 0", ap_idle, carry_seen); end
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ap_done !== 1'b0) done_cnt++;
            if (k == 1) begin
                axis.s_a_tvalid = 1'b0; axis.s_b_tvalid = 1'b0; axis.m_tready = 1'b1;
                rst_n = 1'b1;
            end
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
        fill_random(2);
        run_stream(2, 2'b00, 100, 100, -1, 2);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL abort_rerun_count: got %0d expected 2", got_data.size()); end
        for (int i = 0; i < 2; i++) begin
            exp_beat = model_beat(a_beats[i], b_beats[i], 2'b00, c);
            checks++;
            if (i >= got_data.size() || got_data[i] !== exp_beat || got_last[i] !== (i == 1)) begin
                errors++; $display("FAIL abort_rerun_beat%0d: got %h last %b expected %h last %b", i, got_data[i], got_last[i], exp_beat, (i == 1));
            end
        end
        checks++; if (done_lat != 0) begin errors++; $display("FAIL abort_rerun_done: got %0d expected 0", done_lat); end
        $display("test_reset_abort: rerun %0d beats, done latency %0d", got_data.size(), done_lat);
    endtask

    initial begin
        axis.s_a_tvalid = 1'b0; axis.s_b_tvalid = 1'b0; axis.m_tready = 1'b0;
        axis.s_a_tdata = '0; axis.s_b_tdata = '0;
        test_reset();
        test_basic();
        test_sub_borrow();
        test_saturate();
        test_zero_length();
        test_backpressure();
        test_random_modes();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
